// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 core constants and issue-FSM state type
package rv32_pkg;
    localparam int REG_NUM_W = 5;
    localparam int NUM_REGS  = 32;
    localparam int XLEN      = 32;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } issue_state_e;
endpackage

// File: rtl/dec_issue_ctl_if.sv
// rtl/dec_issue_ctl_if.sv - decode/execute issue bus (DEC_ISSUE_PERF_EN adds perf counter)
interface dec_issue_ctl_if;
    import rv32_pkg::*;

    logic                 instr_vld_ifu_2_dec_i;
    logic [REG_NUM_W-1:0] rs1_num_i;
    logic [REG_NUM_W-1:0] rs2_num_i;
    logic                 rs1_use_i;
    logic                 rs2_use_i;
    logic [REG_NUM_W-1:0] rd_num_i;
    logic                 rd_wen_i;
    logic                 exe_rdy_i;
    logic                 wb_vld_i;
    logic [REG_NUM_W-1:0] wb_rd_i;
    logic                 wb_rd_wen_i;
    logic                 flush_from_exe;
    logic                 flush_from_dec;
    logic                 issue_vld_dec_2_exe_o;
    logic                 dec_rdy_o;
    logic                 stall_o;
    logic [NUM_REGS-1:0]  busy_o;
`ifdef DEC_ISSUE_PERF_EN
    logic [XLEN-1:0]      perf_stall_cnt_o;
`endif

    modport master (
        output instr_vld_ifu_2_dec_i, rs1_num_i, rs2_num_i, rs1_use_i, rs2_use_i,
               rd_num_i, rd_wen_i, exe_rdy_i, wb_vld_i, wb_rd_i, wb_rd_wen_i,
               flush_from_exe, flush_from_dec,
`ifdef DEC_ISSUE_PERF_EN
        input  perf_stall_cnt_o,
`endif
        input  issue_vld_dec_2_exe_o, dec_rdy_o, stall_o, busy_o
    );

    modport slave (
        input  instr_vld_ifu_2_dec_i, rs1_num_i, rs2_num_i, rs1_use_i, rs2_use_i,
               rd_num_i, rd_wen_i, exe_rdy_i, wb_vld_i, wb_rd_i, wb_rd_wen_i,
               flush_from_exe, flush_from_dec,
`ifdef DEC_ISSUE_PERF_EN
        output perf_stall_cnt_o,
`endif
        output issue_vld_dec_2_exe_o, dec_rdy_o, stall_o, busy_o
    );
endinterface

// File: rtl/dec_scoreboard.sv
// rtl/dec_scoreboard.sv - register busy-bit scoreboard with RAW/WAW hazard lookup
module dec_scoreboard
    import rv32_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_all,
    input  logic                 set_en,
    input  logic [REG_NUM_W-1:0] set_rd,
    input  logic                 clr_en,
    input  logic [REG_NUM_W-1:0] clr_rd,
    input  logic [REG_NUM_W-1:0] rs1,
    input  logic                 rs1_use,
    input  logic [REG_NUM_W-1:0] rs2,
    input  logic                 rs2_use,
    input  logic [REG_NUM_W-1:0] rd,
    input  logic                 rd_wen,
    output logic [NUM_REGS-1:0]  busy,
    output logic                 haz
);
    logic [NUM_REGS-1:0] busy_nxt;

    // Set is applied after clear so an issue and a retire of the same rd leave it busy.
    always_comb begin
        busy_nxt = busy;
        if (clr_en)
            busy_nxt[clr_rd] = 1'b0;
        if (set_en)
            busy_nxt[set_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
        if (clr_all)
            busy_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign haz = (rs1_use & busy[rs1]) | (rs2_use & busy[rs2]) | (rd_wen & busy[rd]);
endmodule

// File: rtl/dec_issue_ctl.sv
// rtl/dec_issue_ctl.sv - RV32I decode issue controller; DEC_ISSUE_PERF_EN adds stall counter
module dec_issue_ctl
    import rv32_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int FLUSH_CYCLES    = 2
) (
    input logic           clk,
    input logic           rst_n,
    dec_issue_ctl_if.slave bus
);
    issue_state_e state, state_nxt;
    logic [2:0]   fcnt, fcnt_nxt;
    logic [3:0]   cnt, cnt_nxt;
    logic         flush_in;
    logic         haz;
    logic         issue;
    logic         wb_dec;
    logic [NUM_REGS-1:0] busy;

    assign flush_in = bus.flush_from_exe | bus.flush_from_dec;

    // rst_n gating keeps the combinational outputs low while reset is held.
    assign issue = rst_n & bus.instr_vld_ifu_2_dec_i & (state == ST_RUN) & ~haz
                 & (cnt < 4'(MAX_OUTSTANDING)) & bus.exe_rdy_i & ~flush_in;
    assign wb_dec = bus.wb_vld_i & (cnt != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            fcnt  <= 3'd0;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (flush_in) begin
                    state_nxt = ST_FLUSH;
                    fcnt_nxt  = 3'(FLUSH_CYCLES);
                    cnt_nxt   = 4'd0;
                end else if (issue && !wb_dec) begin
                    cnt_nxt = cnt + 4'd1;
                end else if (!issue && wb_dec) begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_FLUSH: begin
                cnt_nxt = 4'd0;
                if (flush_in) begin
                    fcnt_nxt = 3'(FLUSH_CYCLES);
                end else if (fcnt <= 3'd1) begin
                    state_nxt = ST_RUN;
                    fcnt_nxt  = 3'd0;
                end else begin
                    fcnt_nxt = fcnt - 3'd1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    dec_scoreboard u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_all (flush_in),
        .set_en  (issue & bus.rd_wen_i),
        .set_rd  (bus.rd_num_i),
        .clr_en  (bus.wb_vld_i & bus.wb_rd_wen_i & (state == ST_RUN)),
        .clr_rd  (bus.wb_rd_i),
        .rs1     (bus.rs1_num_i),
        .rs1_use (bus.rs1_use_i),
        .rs2     (bus.rs2_num_i),
        .rs2_use (bus.rs2_use_i),
        .rd      (bus.rd_num_i),
        .rd_wen  (bus.rd_wen_i),
        .busy    (busy),
        .haz     (haz)
    );

    assign bus.issue_vld_dec_2_exe_o = issue;
    assign bus.dec_rdy_o             = issue;
    assign bus.stall_o               = rst_n & bus.instr_vld_ifu_2_dec_i & ~issue;
    assign bus.busy_o                = busy;

`ifdef DEC_ISSUE_PERF_EN
    logic [XLEN-1:0] perf_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_cnt <= '0;
        else if ((bus.stall_o || state == ST_FLUSH) && perf_cnt != {XLEN{1'b1}})
            perf_cnt <= perf_cnt + 1'b1;
    end

    assign bus.perf_stall_cnt_o = perf_cnt;
`endif
endmodule

// File: tb/tb_dec_issue_ctl.sv
// tb/tb_dec_issue_ctl.sv - randomized bench with behavioural scoreboard/issue model
module tb_dec_issue_ctl;
    import rv32_pkg::*;

    localparam int MAXO = 4;
    localparam int FC   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dec_issue_ctl_if bus ();

    dec_issue_ctl #(.MAX_OUTSTANDING(MAXO), .FLUSH_CYCLES(FC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: set of busy registers, outstanding count, remaining bubble cycles.
    bit     m_busy [32];
    int     m_cnt;
    int     m_flush_left;
    longint m_perf;
    bit     e_haz, e_fl, e_issue, e_stall, e_dec;
    logic [31:0] e_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_cnt        = 0;
        m_flush_left = 0;
        m_perf       = 0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        e_fl  = bus.flush_from_exe || bus.flush_from_dec;
        e_haz = (bus.rs1_use_i && m_busy[bus.rs1_num_i]) ||
                (bus.rs2_use_i && m_busy[bus.rs2_num_i]) ||
                (bus.rd_wen_i  && m_busy[bus.rd_num_i]);
        e_issue = rst_n && bus.instr_vld_ifu_2_dec_i && m_flush_left == 0 && !e_haz
                  && m_cnt < MAXO && bus.exe_rdy_i && !e_fl;
        e_stall = rst_n && bus.instr_vld_ifu_2_dec_i && !e_issue;
        for (int i = 0; i < 32; i++) e_busy[i] = m_busy[i];

        chk("issue_vld", 64'(bus.issue_vld_dec_2_exe_o), 64'(e_issue));
        chk("dec_rdy",   64'(bus.dec_rdy_o),             64'(e_issue));
        chk("stall",     64'(bus.stall_o),               64'(e_stall));
        chk("busy",      64'(bus.busy_o),                64'(e_busy));
`ifdef DEC_ISSUE_PERF_EN
        chk("perf_cnt",  64'(bus.perf_stall_cnt_o),      64'(m_perf));
`endif

        if (!rst_n) begin
            model_reset();
        end else begin
            if ((e_stall || m_flush_left > 0) && m_perf < 64'hFFFF_FFFF)
                m_perf++;
            if (e_fl) begin
                foreach (m_busy[i]) m_busy[i] = 1'b0;
                m_cnt        = 0;
                m_flush_left = FC;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end else begin
                e_dec = bus.wb_vld_i && m_cnt > 0;
                if (bus.wb_vld_i && bus.wb_rd_wen_i)
                    m_busy[bus.wb_rd_i] = 1'b0;
                if (e_issue && bus.rd_wen_i && bus.rd_num_i != 5'd0)
                    m_busy[bus.rd_num_i] = 1'b1;
                m_cnt = m_cnt + (e_issue ? 1 : 0) - (e_dec ? 1 : 0);
            end
        end
    end

    task automatic idle();
        bus.instr_vld_ifu_2_dec_i = 1'b0;
        bus.rs1_num_i      = 5'd0;
        bus.rs2_num_i      = 5'd0;
        bus.rs1_use_i      = 1'b0;
        bus.rs2_use_i      = 1'b0;
        bus.rd_num_i       = 5'd0;
        bus.rd_wen_i       = 1'b0;
        bus.exe_rdy_i      = 1'b1;
        bus.wb_vld_i       = 1'b0;
        bus.wb_rd_i        = 5'd0;
        bus.wb_rd_wen_i    = 1'b0;
        bus.flush_from_exe = 1'b0;
        bus.flush_from_dec = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input int rd, input bit wen);
        idle();
        bus.instr_vld_ifu_2_dec_i = 1'b1;
        bus.rd_num_i = 5'(rd);
        bus.rd_wen_i = wen;
    endtask

    task automatic wb(input int rd, input bit wen);
        idle();
        bus.wb_vld_i    = 1'b1;
        bus.wb_rd_i     = 5'(rd);
        bus.wb_rd_wen_i = wen;
    endtask

`ifdef DEC_ISSUE_PERF_EN
    logic [31:0] perf0;
`endif

    initial begin
        instr(5, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_issue", 64'(bus.issue_vld_dec_2_exe_o), 64'd0);
        chk("rst_stall", 64'(bus.stall_o), 64'd0);
        chk("rst_busy",  64'(bus.busy_o), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // first issue after reset, rs1=x0
        instr(5, 1'b1); bus.rs1_use_i = 1'b1;
        #1 chk("t1_issue", 64'(bus.issue_vld_dec_2_exe_o), 64'd1);
        tick(); idle();
        #1 chk("t1_busy", 64'(bus.busy_o), 64'h20);

        // RAW on x5 until retire
        instr(6, 1'b1); bus.rs1_use_i = 1'b1; bus.rs1_num_i = 5'd5;
        #1 chk("t2_stall_a", 64'(bus.stall_o), 64'd1);
        tick();
        bus.wb_vld_i = 1'b1; bus.wb_rd_i = 5'd5; bus.wb_rd_wen_i = 1'b1;
        #1 chk("t2_stall_b", 64'(bus.stall_o), 64'd1);
        tick();
        bus.wb_vld_i = 1'b0;
        #1 chk("t2_issue", 64'(bus.issue_vld_dec_2_exe_o), 64'd1);
        tick(); wb(6, 1'b1); tick();

        // x0 writes never mark busy
        for (int i = 0; i < 3; i++) begin
            instr(0, 1'b1);
            #1 chk("t3_issue", 64'(bus.issue_vld_dec_2_exe_o), 64'd1);
            tick();
        end
        idle();
        #1 chk("t3_busy", 64'(bus.busy_o), 64'd0);
        for (int i = 0; i < 3; i++) begin wb(0, 1'b0); tick(); end

        // fill the outstanding window
        for (int i = 0; i < 5; i++) begin
            instr(10 + i, 1'b1);
            #1;
            if (i < 4) begin
                chk("t4_issue", 64'(bus.issue_vld_dec_2_exe_o), 64'd1);
                tick();
            end else begin
                chk("t4_full", 64'(bus.stall_o), 64'd1);
            end
        end
        bus.wb_vld_i = 1'b1; bus.wb_rd_i = 5'd10; bus.wb_rd_wen_i = 1'b1;
        #1 chk("t4_wb_same", 64'(bus.stall_o), 64'd1);
        tick(); bus.wb_vld_i = 1'b0;
        #1 chk("t4_fifth", 64'(bus.issue_vld_dec_2_exe_o), 64'd1);
        tick(); instr(15, 1'b1);
        #1 chk("t4_still_full", 64'(bus.stall_o), 64'd1);
        tick();
        for (int i = 11; i < 15; i++) begin wb(i, 1'b1); tick(); end

        // flush with x7 busy and three outstanding
        instr(7, 1'b1); tick(); instr(0, 1'b0); tick(); instr(0, 1'b0); tick();
        instr(8, 1'b1); bus.flush_from_exe = 1'b1;
        #1 chk("t5_flush_issue", 64'(bus.issue_vld_dec_2_exe_o), 64'd0);
        tick(); bus.flush_from_exe = 1'b0;
        #1 chk("t5_busy_clr", 64'(bus.busy_o), 64'd0);
        chk("t5_bubble1", 64'(bus.issue_vld_dec_2_exe_o), 64'd0);
        tick();
        #1 chk("t5_bubble2", 64'(bus.issue_vld_dec_2_exe_o), 64'd0);
        tick();
        #1 chk("t5_resume", 64'(bus.issue_vld_dec_2_exe_o), 64'd1);
        tick(); wb(8, 1'b1); tick();

        // issue and retire of x9 in the same cycle
        instr(0, 1'b0); tick();
        instr(9, 1'b1); bus.wb_vld_i = 1'b1; bus.wb_rd_i = 5'd9; bus.wb_rd_wen_i = 1'b1;
        #1 chk("t6_issue", 64'(bus.issue_vld_dec_2_exe_o), 64'd1);
        tick(); idle();
        #1 chk("t6_busy", 64'(bus.busy_o), 64'h200);
        wb(9, 1'b1); tick(); wb(0, 1'b0); tick();

`ifdef DEC_ISSUE_PERF_EN
        idle();
        perf0 = bus.perf_stall_cnt_o;
        instr(3, 1'b1); tick();
        instr(4, 1'b1); bus.rs1_use_i = 1'b1; bus.rs1_num_i = 5'd3;
        repeat (3) tick();
        idle(); bus.flush_from_dec = 1'b1; tick();
        idle(); repeat (2) tick();
        #1 chk("t7_perf", 64'(bus.perf_stall_cnt_o - perf0), 64'd5);
`endif

        // random phase
        for (int n = 0; n < 1500; n++) begin
            bus.instr_vld_ifu_2_dec_i = ($urandom_range(3) != 0);
            bus.rs1_num_i      = 5'($urandom_range(7));
            bus.rs2_num_i      = 5'($urandom_range(7));
            bus.rs1_use_i      = 1'($urandom_range(1));
            bus.rs2_use_i      = 1'($urandom_range(1));
            bus.rd_num_i       = 5'($urandom_range(7));
            bus.rd_wen_i       = 1'($urandom_range(1));
            bus.exe_rdy_i      = ($urandom_range(3) != 0);
            bus.wb_vld_i       = 1'($urandom_range(1));
            bus.wb_rd_i        = 5'($urandom_range(7));
            bus.wb_rd_wen_i    = 1'($urandom_range(1));
            bus.flush_from_exe = ($urandom_range(29) == 0);
            bus.flush_from_dec = ($urandom_range(29) == 0);
            tick();
        end
        idle();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
